// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Two-stage pipelined branch resolution unit for the execute stage.
//   S1: operand register, loaded on the in_valid/in_ready handshake.
//   S2: output register. It holds the compare result, the next-PC target and
//       the redirect/illegal flags that were computed from the S1 contents.
// The latency is 2 cycles from accept to out_valid. Throughput is one
// operation per cycle, and the unit supports full valid/ready backpressure.
//
// Configuration macro:
//   BRU_PREDICT_CHECK_EN  When defined, in_pred_taken is carried to S2 and
//                         out_redirect flags a misprediction
//                         (taken != predicted). When undefined, the front end
//                         is assumed to predict not-taken statically, so every
//                         legal taken branch redirects.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   flush                 synchronous kill of all in-flight operations
//   in_valid / in_ready   input handshake; in_ready does not depend on in_valid
//   in_x, in_y            rs1 / rs2 operands (XLEN)
//   in_funct3             BEQ/BNE/BLT/BGE/BLTU/BGEU; 010 and 011 are illegal
//   in_pc, in_imm         branch PC and sign-extended B-immediate (PC_W)
//   in_pred_taken         front-end prediction
//   in_tag                opaque tag that travels with the operation
//   out_valid / out_ready output handshake
//   out_taken             branch condition result
//   out_target            taken ? pc+imm : pc+4, modulo 2^PC_W
//   out_redirect          the front end must refetch from out_target
//   out_illegal           funct3 was 010 or 011
//   out_tag               tag of the result being presented
//   cnt_resolved          saturating count of results accepted at the output
//   cnt_taken             saturating count of accepted results with out_taken=1
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_x,
  input  logic [XLEN-1:0]  in_y,
  input  logic [2:0]       in_funct3,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [PC_W-1:0]  out_target,
  output logic             out_redirect,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // S1 state
  logic             s1_valid;
  logic [XLEN-1:0]  s1_x, s1_y;
  logic [2:0]       s1_funct3;
  logic [PC_W-1:0]  s1_pc, s1_imm;
  logic [TAG_W-1:0] s1_tag;
`ifdef BRU_PREDICT_CHECK_EN
  logic             s1_pred;
`else
  // The prediction is ignored in this build. The name keeps it out of the
  // unused-signal report.
  logic             unused_pred;
  assign unused_pred = in_pred_taken;
`endif

  // Handshake / advance control
  logic s1_adv, s2_adv, accept, out_fire;

  // Evaluation of the S1 contents, registered into S2
  logic            ev_taken, ev_illegal, ev_redirect;
  logic [PC_W-1:0] ev_target;

  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    // flush blocks acceptance so that a same-cycle input cannot survive the kill.
    in_ready = s1_adv && !flush;
    accept   = in_valid && in_ready;
    out_fire = out_valid && out_ready && !flush;
  end

  always_comb begin
    // NOTE: every output of an always_comb gets a default first. A path that
    // misses an assignment would otherwise infer a latch.
    ev_taken   = 1'b0;
    ev_illegal = 1'b0;
    unique case (s1_funct3)
      F3_BEQ:  ev_taken = (s1_x == s1_y);
      F3_BNE:  ev_taken = (s1_x != s1_y);
      F3_BLT:  ev_taken = ($signed(s1_x) <  $signed(s1_y));
      F3_BGE:  ev_taken = ($signed(s1_x) >= $signed(s1_y));
      F3_BLTU: ev_taken = (s1_x <  s1_y);
      F3_BGEU: ev_taken = (s1_x >= s1_y);
      default: ev_illegal = 1'b1;   // 010 / 011
    endcase
    // The adds wrap naturally at PC_W bits.
    ev_target = ev_taken ? (s1_pc + s1_imm) : (s1_pc + PC_W'(4));
`ifdef BRU_PREDICT_CHECK_EN
    ev_redirect = !ev_illegal && (ev_taken != s1_pred);
`else
    ev_redirect = ev_taken && !ev_illegal;
`endif
  end

  // S1 valid bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples its pre-edge value regardless of block ordering.
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // S1 payload
  // NOTE: the payload registers are deliberately left without reset. They
  // are qualified by s1_valid, and leaving them off the reset tree keeps them
  // as plain enable flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_x      <= in_x;
      s1_y      <= in_y;
      s1_funct3 <= in_funct3;
      s1_pc     <= in_pc;
      s1_imm    <= in_imm;
      s1_tag    <= in_tag;
`ifdef BRU_PREDICT_CHECK_EN
      s1_pred   <= in_pred_taken;
`endif
    end
  end

  // S2 output register. The outputs are architecturally visible, so all of
  // them reset to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_redirect <= 1'b0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      // The payload changes only when a real op moves in. Held data stays
      // stable while the output is stalled.
      if (s1_valid) begin
        out_taken    <= ev_taken;
        out_target   <= ev_target;
        out_redirect <= ev_redirect;
        out_illegal  <= ev_illegal;
        out_tag      <= s1_tag;
      end
    end
  end

  // Saturating statistics counters. A flushed result is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_resolved <= '0;
      cnt_taken    <= '0;
    end else if (out_fire) begin
      if (cnt_resolved != CNT_MAX) cnt_resolved <= cnt_resolved + 1'b1;
      if (out_taken && cnt_taken != CNT_MAX) cnt_taken <= cnt_taken + 1'b1;
    end
  end

endmodule
